// File: rtl/passcoder_pkg.sv
// Shared passcode constants and entry FSM state type; also used by the keypad scanner
// and the lock controller.
package passcoder_pkg;

  localparam logic [3:0] KEY_DEL = 4'hA;
  localparam logic [3:0] KEY_CLR = 4'hB;
  localparam logic [3:0] KEY_ENT = 4'hE;

  localparam int unsigned DIGITS = 4;

  typedef enum logic [1:0] {
    StIdle,
    StEntry,
    StFull,
    StDone
  } entry_state_e;

endpackage

// File: rtl/entry_timeout.sv
// Inactivity counter: counts enabled cycles, restarts on kick, pulses expire combinationally
// on the last cycle of the period. TIMEOUT_CYCLES == 0 disables it.
module entry_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic kick,
  output logic expire
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] Last = (TIMEOUT_CYCLES > 0) ? CntW'(TIMEOUT_CYCLES - 1) : '0;

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    expire = 1'b0;
    cnt_d  = cnt_q;
    if (kick || !enable || (TIMEOUT_CYCLES == 0)) begin
      cnt_d = '0;
    end else if (cnt_q == Last) begin
      expire = 1'b1;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/passcode_entry.sv
// Passcode entry buffer: collects up to four BCD keys, handles delete/clear/enter and
// inactivity timeout, and presents the digits plus one-cycle status pulses.
module passcode_entry
  import passcoder_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000,
  parameter int unsigned DIGIT_MAX      = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [3:0] digit4,
  output logic [2:0] count,
  output logic       frame_valid,
  output logic       short_err,
  output logic       ovf_err,
  output logic       timeout
);

  localparam logic [3:0] DigitMax = 4'(DIGIT_MAX);

  entry_state_e              state_q, state_d;
  logic [DIGITS-1:0][3:0]    dig_q, dig_d;
  logic [2:0]                count_q, count_d;
  logic                      fv_q, fv_d, se_q, se_d, ovf_q, ovf_d, to_q, to_d;
  logic                      idle_en, expire;
  logic [1:0]                wr_slot, del_slot;

  assign idle_en  = (state_q == StEntry) || (state_q == StFull);
  assign wr_slot  = count_q[1:0];
  assign del_slot = 2'(count_q - 3'd1);

  entry_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .enable(idle_en),
    .kick  (key_valid),
    .expire(expire)
  );

  always_comb begin
    state_d = state_q;
    dig_d   = dig_q;
    count_d = count_q;
    fv_d    = 1'b0;
    se_d    = 1'b0;
    ovf_d   = 1'b0;
    to_d    = 1'b0;
    if (key_valid) begin
      // Edit keys decode first so a widened DIGIT_MAX can never shadow them.
      if (key_code == KEY_CLR) begin
        dig_d   = '0;
        count_d = 3'd0;
        state_d = StIdle;
      end else if (key_code == KEY_DEL) begin
        if (idle_en) begin
          dig_d[del_slot] = 4'd0;
          count_d         = count_q - 3'd1;
          state_d         = (count_q == 3'd1) ? StIdle : StEntry;
        end
      end else if (key_code == KEY_ENT) begin
        unique case (state_q)
          StFull: begin
            fv_d    = 1'b1;
            state_d = StDone;
          end
          StIdle, StEntry: se_d = 1'b1;
          StDone: ;
          default: ;
        endcase
      end else if (key_code <= DigitMax) begin
        unique case (state_q)
          StIdle, StEntry: begin
            dig_d[wr_slot] = key_code;
            count_d        = count_q + 3'd1;
            state_d        = (count_q == 3'd3) ? StFull : StEntry;
          end
          StFull: ovf_d = 1'b1;
          StDone: begin
            dig_d    = '0;
            dig_d[0] = key_code;
            count_d  = 3'd1;
            state_d  = StEntry;
          end
          default: ;
        endcase
      end
    end else if (expire) begin
      dig_d   = '0;
      count_d = 3'd0;
      state_d = StIdle;
      to_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      dig_q   <= '0;
      count_q <= 3'd0;
      fv_q    <= 1'b0;
      se_q    <= 1'b0;
      ovf_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dig_q   <= dig_d;
      count_q <= count_d;
      fv_q    <= fv_d;
      se_q    <= se_d;
      ovf_q   <= ovf_d;
      to_q    <= to_d;
    end
  end

  assign digit1      = dig_q[0];
  assign digit2      = dig_q[1];
  assign digit3      = dig_q[2];
  assign digit4      = dig_q[3];
  assign count       = count_q;
  assign frame_valid = fv_q;
  assign short_err   = se_q;
  assign ovf_err     = ovf_q;
  assign timeout     = to_q;

endmodule
